// File: rtl/trees_spawner_if.sv
// rtl/trees_spawner_if.sv - tree bus between the slot manager and the per-tree consumers
interface trees_spawner_if #(
  parameter int NUMBER_OF_TREES = 16
);
  logic                                        enable;
  logic                                        startOfFrame;
  logic [3:0]                                  scrollSpeed;
  logic [NUMBER_OF_TREES-1:0]                  treeHit;
  logic signed [NUMBER_OF_TREES-1:0][1:0][10:0] treesCoordinates;
  logic [NUMBER_OF_TREES-1:0]                  isActive;
  logic [NUMBER_OF_TREES-1:0]                  deploy_tree;
  logic                                        spawnFull;

  // master is the slot manager that owns the tree bus; slave is the frame/collision side
  modport master (
    input  enable, startOfFrame, scrollSpeed, treeHit,
    output treesCoordinates, isActive, deploy_tree, spawnFull
  );
  modport slave (
    output enable, startOfFrame, scrollSpeed, treeHit,
    input  treesCoordinates, isActive, deploy_tree, spawnFull
  );
endinterface

// File: rtl/trees_spawner.sv
// rtl/trees_spawner.sv - tree-slot manager: spawn, scroll and retire of 16 tree slots
// One frame walks IDLE -> MOVE -> SPAWN; spawn timing and height come from a 16-bit LFSR.
module trees_spawner #(
  parameter int SCREEN_WIDTH = 640,
  parameter int TREE_WIDTH   = 64,
  parameter int TREE_Y_MIN   = 300,
  parameter int SPAWN_MIN    = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  trees_spawner_if.master bus
);
  localparam int N = 16;
  localparam logic signed [11:0] RETIRE_X = 12'(-TREE_WIDTH);

  typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

  state_t                       state_q;
  logic [5:0]                   cnt_q;
  logic [15:0]                  lfsr_q;
  logic [15:0]                  lfsr_d;
  logic signed [N-1:0][1:0][10:0] coord_q;
  logic [N-1:0]                 active_q;
  logic [N-1:0]                 deploy_q;

  logic                         free_found;
  logic [3:0]                   free_idx;
  logic signed [11:0]           moved_x [N];
  logic [N-1:0]                 retire;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    retire = '0;
    for (int i = 0; i < N; i++) begin
      moved_x[i] = {coord_q[i][0][10], coord_q[i][0]} - {8'b0, bus.scrollSpeed};
      retire[i]  = moved_x[i] < RETIRE_X;
    end
  end

  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= 6'(SPAWN_MIN);
      lfsr_q   <= 16'hACE1;
      coord_q  <= '0;
      active_q <= '0;
      deploy_q <= '0;
    end else begin
      deploy_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.startOfFrame && bus.enable) state_q <= MOVE;
        end
        MOVE: begin
          for (int i = 0; i < N; i++) begin
            if (active_q[i]) begin
              if (retire[i]) active_q[i] <= 1'b0;
              else           coord_q[i][0] <= moved_x[i][10:0];
            end
          end
          state_q <= SPAWN;
        end
        SPAWN: begin
          if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
          end else begin
            if (free_found) begin
              coord_q[free_idx][0] <= 11'(SCREEN_WIDTH);
              coord_q[free_idx][1] <= 11'(TREE_Y_MIN) + {4'b0, lfsr_q[6:0]};
              active_q[free_idx]   <= 1'b1;
              deploy_q[free_idx]   <= 1'b1;
            end
            cnt_q  <= 6'(SPAWN_MIN) + {2'b0, lfsr_q[11:8]};
            lfsr_q <= lfsr_d;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Placed after the case so a hit overrides a move or deploy on the same slot
      for (int i = 0; i < N; i++) begin
        if (bus.treeHit[i]) active_q[i] <= 1'b0;
      end
    end
  end

  assign bus.treesCoordinates = coord_q;
  assign bus.isActive         = active_q;
  assign bus.deploy_tree      = deploy_q;
  assign bus.spawnFull        = &active_q;
endmodule

// File: tb/tb_trees_spawner.sv
// tb/tb_trees_spawner.sv - directed bench for trees_spawner with a frame-level reference model
module tb_trees_spawner;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trees_spawner_if bus_if ();
  trees_spawner dut (.clk_i(clk), .reset_i(reset), .bus(bus_if));

  int errors = 0;
  int checks = 0;

  int          mx [16];
  int          my [16];
  logic [15:0] mact;
  logic [15:0] mdep;
  int          mcnt;
  logic [15:0] mlfsr;
  bit          move_due;
  bit          spawn_due;
  bit          start_frame;
  bit          model_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int xof(input int i);
    return int'($signed(bus_if.treesCoordinates[i][0]));
  endfunction

  function automatic int yof(input int i);
    return int'($signed(bus_if.treesCoordinates[i][1]));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (fb << 15));
  endfunction

  task automatic model_move();
    int nx;
    for (int i = 0; i < 16; i++) begin
      if (mact[i]) begin
        nx = mx[i] - int'(bus_if.scrollSpeed);
        if (nx < -64) mact[i] = 1'b0;
        else          mx[i] = nx;
      end
    end
  endtask

  task automatic model_spawn();
    int slot;
    if (mcnt > 0) begin
      mcnt--;
    end else begin
      slot = -1;
      for (int i = 15; i >= 0; i--) if (!mact[i]) slot = i;
      if (slot >= 0) begin
        mx[slot]   = 640;
        my[slot]   = 300 + int'(mlfsr[6:0]);
        mact[slot] = 1'b1;
        mdep[slot] = 1'b1;
      end
      mcnt  = 8 + int'(mlfsr[11:8]);
      mlfsr = lfsr_step(mlfsr);
    end
  endtask

  // A frame is accepted only when no earlier frame is still being processed
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mx[i] = 0;
        my[i] = 0;
      end
      mact = '0; mdep = '0; mcnt = 8; mlfsr = 16'hACE1;
      move_due = 1'b0; spawn_due = 1'b0; model_valid = 1'b1;
    end else if (model_valid) begin
      start_frame = !move_due && !spawn_due && bus_if.startOfFrame && bus_if.enable;
      mdep = '0;
      if (spawn_due) model_spawn();
      if (move_due)  model_move();
      spawn_due = move_due;
      move_due  = start_frame;
      for (int i = 0; i < 16; i++) if (bus_if.treeHit[i]) mact[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      int bad;
      bad = -1;
      for (int i = 0; i < 16; i++)
        if (bad < 0 && (xof(i) != mx[i] || yof(i) != my[i])) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL coords slot %0d: got x=%0d y=%0d expected x=%0d y=%0d",
                 bad, xof(bad), yof(bad), mx[bad], my[bad]);
      end
      check("isActive", int'(bus_if.isActive), int'(mact));
      check("deploy_tree", int'(bus_if.deploy_tree), int'(mdep));
      check("spawnFull", int'(bus_if.spawnFull), int'(&mact));
    end
  end

  task automatic frame();
    bus_if.startOfFrame = 1'b1;
    @(negedge clk);
    bus_if.startOfFrame = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    bus_if.enable = 1'b0;
    bus_if.startOfFrame = 1'b0;
    bus_if.scrollSpeed = 4'd0;
    bus_if.treeHit = '0;
    @(negedge clk);
    do_reset();

    check("reset isActive", int'(bus_if.isActive), 0);
    check("reset deploy", int'(bus_if.deploy_tree), 0);
    check("reset spawnFull", int'(bus_if.spawnFull), 0);
    check("reset x0", xof(0), 0);
    check("model seed", int'(mlfsr), 16'hACE1);

    // first spawn on frame 9
    bus_if.enable = 1'b1;
    frames(8);
    check("no deploy in 8 frames", int'(bus_if.isActive), 0);
    frame();
    check("frame9 deploy", int'(bus_if.deploy_tree), 16'h0001);
    check("frame9 x", xof(0), 640);
    check("frame9 y", yof(0), 397);
    check("model reload", mcnt, 20);
    check("model lfsr step", int'(mlfsr), 16'h5670);
    @(negedge clk);
    check("deploy one cycle", int'(bus_if.deploy_tree), 0);

    bus_if.scrollSpeed = 4'd4;
    bus_if.startOfFrame = 1'b1;
    @(negedge clk);
    bus_if.startOfFrame = 1'b0;
    check("x before move", xof(0), 640);
    @(negedge clk);
    check("x after move", xof(0), 636);
    @(negedge clk);

    bus_if.scrollSpeed = 4'd12;
    frames(58);
    check("x reaches -60", xof(0), -60);
    bus_if.scrollSpeed = 4'd4;
    frame();
    check("x at -64", xof(0), -64);
    check("-64 active", int'(bus_if.isActive[0]), 1);

    do_reset();
    bus_if.scrollSpeed = 4'd0;
    frames(9);
    bus_if.scrollSpeed = 4'd14;
    frames(50);
    check("x -60 again", xof(0), -60);
    bus_if.scrollSpeed = 4'd8;
    frame();
    check("retired inactive", int'(bus_if.isActive[0]), 0);
    check("retired x held", xof(0), -60);

    // fill every slot, then force an attempt with nothing free
    do_reset();
    bus_if.scrollSpeed = 4'd0;
    n = 0;
    while (mact != 16'hFFFF && n < 500) begin frame(); n++; end
    check("full isActive", int'(bus_if.isActive), 16'hFFFF);
    check("full spawnFull", int'(bus_if.spawnFull), 1);
    n = 0;
    while (mcnt != 0 && n < 30) begin frame(); n++; end
    frame();
    check("full no deploy", int'(bus_if.deploy_tree), 0);
    bus_if.treeHit = 16'h0020;
    @(negedge clk);
    bus_if.treeHit = '0;
    check("hit slot5", int'(bus_if.isActive), 16'hFFDF);
    n = 0;
    while (mact != 16'hFFFF && n < 40) begin frame(); n++; end
    check("refilled", int'(bus_if.isActive), 16'hFFFF);

    // hit on slot 1 during the SPAWN cycle of an attempt
    do_reset();
    n = 0;
    while (mact[2:0] != 3'b111 && n < 200) begin frame(); n++; end
    n = 0;
    while (mcnt != 0 && n < 30) begin frame(); n++; end
    bus_if.startOfFrame = 1'b1;
    @(negedge clk);
    bus_if.startOfFrame = 1'b0;
    @(negedge clk);
    bus_if.treeHit = 16'h0002;
    @(negedge clk);
    bus_if.treeHit = '0;
    check("hit/spawn deploy", int'(bus_if.deploy_tree), 16'h0008);
    check("hit/spawn active", int'(bus_if.isActive), 16'h000D);

    bus_if.enable = 1'b0;
    bus_if.scrollSpeed = 4'd3;
    frames(5);
    check("stall x3", xof(3), 640);
    check("stall x0", xof(0), 640);
    bus_if.treeHit = 16'h0001;
    @(negedge clk);
    bus_if.treeHit = '0;
    check("hit while disabled", int'(bus_if.isActive), 16'h000C);
    bus_if.enable = 1'b1;
    bus_if.scrollSpeed = 4'd0;
    frames(3);

    // reset landing on the MOVE cycle
    bus_if.scrollSpeed = 4'd2;
    bus_if.startOfFrame = 1'b1;
    @(negedge clk);
    bus_if.startOfFrame = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort isActive", int'(bus_if.isActive), 0);
    check("abort deploy", int'(bus_if.deploy_tree), 0);
    check("abort x3", xof(3), 0);
    @(negedge clk);
    bus_if.scrollSpeed = 4'd0;
    frames(8);
    check("post-abort quiet", int'(bus_if.isActive), 0);
    frame();
    check("post-abort deploy", int'(bus_if.deploy_tree), 16'h0001);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
